scroll_frame_controller: RTL and testbench

//  Owns and sequences the SIZE x WIDTH circular display frame used by the scrolling column display.

---
 rtl/scroll_frame_controller.sv | 118 +++++++++++
 tb/tb_scroll_frame_controller.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/scroll_frame_controller.sv
// scroll_frame_controller: byte-command driven circular column frame with shadow load, rate divider and bidirectional scroll.
module scroll_frame_controller #(
  parameter int WIDTH = 8,
  parameter int SIZE = 16,
  parameter int DIV_WIDTH = 24,
  parameter logic [DIV_WIDTH-1:0] DEFAULT_DIV = 24'd99
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [7:0]            cmd_data,
  output logic [WIDTH*SIZE-1:0] frame_out,
  output logic                  shift_tick,
  output logic                  running,
  output logic                  load_busy
);
  localparam int FW = WIDTH * SIZE;
  localparam int IW = (SIZE > 4) ? $clog2(SIZE) : 2;
  localparam logic [127:0] PAT = 128'h00000000_102040FF_FF402010_00000000;
  typedef enum logic [1:0] {IDLE, LOAD, RATE, COMMIT} state_t;
  function automatic logic [FW-1:0] reset_frame();
    logic [FW-1:0] f;
    f = '0;
    if (SIZE == 16)
      for (int i = 0; i < SIZE && i < 16; i++) f[i*WIDTH +: WIDTH] = WIDTH'(PAT[i*8 +: 8]);
    return f;
  endfunction
  state_t state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [FW-1:0] frame_q, frame_d, shadow_q, shadow_d, rot;
  logic [15:0] rate_q, rate_d;
  logic [DIV_WIDTH-1:0] div_q, div_d, cnt_q, cnt_d;
  logic running_q, running_d, dir_q, dir_d, tick_q, tick_d, busy_q, busy_d;
  logic accept, step, shift;
  always_comb begin
    accept = cmd_valid && state_q != COMMIT;
    step = accept && state_q == IDLE && cmd_data == 8'h05;
    shift = state_q != COMMIT && ((running_q && cnt_q == div_q) || step);
    // dir_q=1 is RIGHT: column i takes column i+1
    rot = dir_q ? {frame_q[WIDTH-1:0], frame_q[FW-1:WIDTH]}
                : {frame_q[FW-WIDTH-1:0], frame_q[FW-1 -: WIDTH]};
    frame_d = (state_q == COMMIT) ? shadow_q : shift ? rot : frame_q;
    cnt_d = (state_q == COMMIT || shift) ? '0 : running_q ? cnt_q + 1'b1 : cnt_q;
    tick_d = shift;
    state_d = state_q;
    idx_d = idx_q;
    shadow_d = shadow_q;
    rate_d = rate_q;
    div_d = div_q;
    running_d = running_q;
    dir_d = dir_q;
    if (state_q == COMMIT) state_d = IDLE;
    else if (accept)
      case (state_q)
        IDLE: begin
          idx_d = '0;
          case (cmd_data)
            8'h01: state_d = LOAD;
            8'h02: state_d = RATE;
            8'h03: running_d = 1'b1;
            8'h04: running_d = 1'b0;
            8'h06: dir_d = 1'b0;
            8'h07: dir_d = 1'b1;
            default: ;
          endcase
        end
        LOAD: begin
          shadow_d[idx_q*WIDTH +: WIDTH] = WIDTH'(cmd_data);
          idx_d = idx_q + 1'b1;
          if (idx_q == IW'(SIZE - 1)) state_d = COMMIT;
        end
        RATE: begin
          rate_d = {rate_q[7:0], cmd_data};
          idx_d = idx_q + 1'b1;
          if (idx_q == IW'(2)) begin
            div_d = DIV_WIDTH'({rate_q, cmd_data});
            cnt_d = '0;
            state_d = IDLE;
          end
        end
        default: ;
      endcase
    busy_d = state_d == LOAD || state_d == COMMIT;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q <= '0;
      frame_q <= reset_frame();
      shadow_q <= '0;
      rate_q <= '0;
      div_q <= DEFAULT_DIV;
      cnt_q <= '0;
      running_q <= 1'b0;
      dir_q <= 1'b0;
      tick_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      frame_q <= frame_d;
      shadow_q <= shadow_d;
      rate_q <= rate_d;
      div_q <= div_d;
      cnt_q <= cnt_d;
      running_q <= running_d;
      dir_q <= dir_d;
      tick_q <= tick_d;
      busy_q <= busy_d;
    end
  end
  assign cmd_ready = state_q != COMMIT;
  assign frame_out = frame_q;
  assign shift_tick = tick_q;
  assign running = running_q;
  assign load_busy = busy_q;
endmodule

// File: tb/tb_scroll_frame_controller.sv
// tb_scroll_frame_controller: directed command sequences checked against a per-column array model every cycle.
module tb_scroll_frame_controller;
  localparam logic [127:0] RP = 128'h00000000_102040FF_FF402010_00000000;
  localparam logic [127:0] RAMP = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
  logic clk = 0, rst, cmd_valid, cmd_ready, shift_tick, running, load_busy;
  logic [7:0] cmd_data;
  logic [127:0] frame_out;
  int n_chk = 0, n_fail = 0;
  bit chk_en = 0;
  int m_col[16], m_sh[16], tmp[16];
  int m_mode, m_idx, m_rate, m_div, m_cnt;
  bit m_run, m_dir, m_tick, m_busy, acc, st, moved;
  scroll_frame_controller dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
    .frame_out(frame_out), .shift_tick(shift_tick), .running(running), .load_busy(load_busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  function automatic logic [7:0] col(input int k);
    return frame_out[k*8 +: 8];
  endfunction
  // mode: 0 idle, 1 collecting frame bytes, 2 collecting rate bytes, 3 commit cycle
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        m_col[i] = int'(RP[i*8 +: 8]);
        m_sh[i] = 0;
      end
      m_mode = 0; m_idx = 0; m_rate = 0; m_div = 99; m_cnt = 0;
      m_run = 0; m_dir = 0; m_tick = 0; m_busy = 0;
    end else begin
      acc = cmd_valid && m_mode != 3;
      moved = 0;
      if (m_mode == 3) begin
        m_col = m_sh;
        m_cnt = 0;
        m_mode = 0;
      end else begin
        st = acc && m_mode == 0 && cmd_data == 8'h05;
        if ((m_run && m_cnt == m_div) || st) begin
          tmp = m_col;
          for (int i = 0; i < 16; i++) m_col[i] = m_dir ? tmp[(i + 1) % 16] : tmp[(i + 15) % 16];
          moved = 1;
          m_cnt = 0;
        end else if (m_run) m_cnt++;
        if (acc)
          case (m_mode)
            0: begin
              m_idx = 0;
              case (cmd_data)
                8'h01: m_mode = 1;
                8'h02: begin m_mode = 2; m_rate = 0; end
                8'h03: m_run = 1;
                8'h04: m_run = 0;
                8'h06: m_dir = 0;
                8'h07: m_dir = 1;
                default: ;
              endcase
            end
            1: begin
              m_sh[m_idx] = int'(cmd_data);
              m_idx++;
              if (m_idx == 16) m_mode = 3;
            end
            2: begin
              m_rate = m_rate * 256 + int'(cmd_data);
              m_idx++;
              if (m_idx == 3) begin m_div = m_rate; m_cnt = 0; m_mode = 0; end
            end
            default: ;
          endcase
      end
      m_tick = moved;
      m_busy = m_mode == 1 || m_mode == 3;
    end
  end
  always @(negedge clk) begin
    logic [127:0] ef;
    if (chk_en) begin
      for (int i = 0; i < 16; i++) ef[i*8 +: 8] = m_col[i][7:0];
      chk("model_frame", frame_out, ef);
      chk("model_shift_tick", 128'(shift_tick), 128'(m_tick));
      chk("model_running", 128'(running), 128'(m_run));
      chk("model_load_busy", 128'(load_busy), 128'(m_busy));
      chk("model_cmd_ready", 128'(cmd_ready), 128'(m_mode != 3));
    end
  end
  task automatic send(input logic [7:0] b);
    int w = 0;
    cmd_valid = 1;
    cmd_data = b;
    while (!cmd_ready && w < 10) begin
      @(negedge clk);
      w++;
    end
    chk("send_ready", 128'(cmd_ready), 128'(1));
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 0;
  endtask
  task automatic run(input int n, output int t);
    t = 0;
    repeat (n) begin
      @(negedge clk);
      if (shift_tick) t++;
    end
  endtask
  task automatic wait_tick(output int c);
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!shift_tick && c < 200);
    chk("tick_seen", 128'(shift_tick), 128'(1));
  endtask
  initial begin
    int t, c;
    rst = 1; cmd_valid = 0; cmd_data = 0;
    repeat (2) @(negedge clk);
    rst = 0;
    chk_en = 1;
    chk("reset_frame", frame_out, RP);
    chk("reset_ready", 128'(cmd_ready), 128'(1));
    chk("reset_busy", 128'(load_busy), 128'(0));
    run(50, t);
    chk("idle_ticks", 128'(t), 128'(0));
    chk("idle_frame", frame_out, RP);
    send(8'h02); send(8'h00); send(8'h00); send(8'h03);
    send(8'h03);
    for (int k = 0; k < 3; k++) begin
      wait_tick(c);
      chk("tick_period", 128'(c), 128'(4));
    end
    chk("left3_col7", 128'(col(7)), 128'(8'h10));
    chk("left3_col1", 128'(col(1)), 128'(8'h00));
    for (int k = 0; k < 13; k++) wait_tick(c);
    chk("left16_restore", frame_out, RP);
    send(8'h04); send(8'h07); send(8'h05);
    chk("step_tick", 128'(shift_tick), 128'(1));
    chk("right_col15", 128'(col(15)), 128'(8'h00));
    chk("right_col3", 128'(col(3)), 128'(8'h10));
    run(4, t);
    chk("step_single", 128'(t), 128'(0));
    send(8'h01);
    chk("load_busy_on", 128'(load_busy), 128'(1));
    for (int k = 0; k < 16; k++) begin
      if (k % 3 == 1) repeat (2) @(negedge clk);
      send(8'(k));
    end
    chk("commit_ready_low", 128'(cmd_ready), 128'(0));
    chk("commit_busy", 128'(load_busy), 128'(1));
    @(negedge clk);
    chk("load_frame", frame_out, RAMP);
    chk("commit_no_tick", 128'(shift_tick), 128'(0));
    chk("commit_ready_back", 128'(cmd_ready), 128'(1));
    chk("commit_busy_off", 128'(load_busy), 128'(0));
    send(8'h02); send(8'h00); send(8'h00); send(8'h00);
    send(8'h06); send(8'h03); send(8'h01);
    for (int k = 0; k < 7; k++) send(8'(8'h20 + k));
    chk("midload_busy", 128'(load_busy), 128'(1));
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("midload_rst_frame", frame_out, RP);
    chk("midload_rst_busy", 128'(load_busy), 128'(0));
    chk("midload_rst_running", 128'(running), 128'(0));
    send(8'hAA);
    chk("bad_op_no_tick", 128'(shift_tick), 128'(0));
    chk("bad_op_frame", frame_out, RP);
    send(8'h05);
    chk("step_after_bad", 128'(shift_tick), 128'(1));
    chk("step_left_col5", 128'(col(5)), 128'(8'h10));
    run(4, t);
    chk("step_once", 128'(t), 128'(0));
    send(8'h02); send(8'h00); send(8'h00); send(8'h00);
    send(8'h03);
    run(3, t);
    send(8'h05);
    run(5, t);
    chk("div0_every_cycle", 128'(t), 128'(5));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1);
  end
endmodule
